// File: rtl/lifo_stack_ctrl.sv
// LIFO stack controller: valid/ready command port, held response port,
// push/pop/peek/replace over a DATA_W x DEPTH array with occupancy flags.
module lifo_stack_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int AFULL  = DEPTH - 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  input  logic              err_clr,
  output logic              ovf_sticky,
  output logic              udf_sticky
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] OP_PUSH    = 2'b00;
  localparam logic [1:0] OP_POP     = 2'b01;
  localparam logic [1:0] OP_PEEK    = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  sp_q, sp_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [AW-1:0]     top_idx;
  logic [DATA_W-1:0] top_data;
  logic              is_empty;
  logic              is_full;
  logic              ovf_set;
  logic              udf_set;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == CNT_W'(DEPTH));
  assign top_idx  = AW'(sp_q - CNT_W'(1));
  // Only read when the stack is non-empty, so top_idx is always in range here.
  assign top_data = mem[top_idx];

  // Command sequencing: latch the command in IDLE, execute once, hold the response.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_EXEC;
          op_d    = cmd_op;
          data_d  = cmd_data;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stack operation, evaluated only in EXEC; guards keep sp inside 0..DEPTH.
  always_comb begin
    sp_d       = sp_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    mem_we     = 1'b0;
    mem_waddr  = top_idx;
    mem_wdata  = data_q;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
    if (state_q == ST_EXEC) begin
      rsp_data_d = '0;
      rsp_err_d  = 1'b0;
      if (op_q == OP_PUSH) begin
        if (is_full) begin
          rsp_err_d = 1'b1;
          ovf_set   = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = AW'(sp_q);
          sp_d      = sp_q + CNT_W'(1);
        end
      end else if (is_empty) begin
        rsp_err_d = 1'b1;
        udf_set   = 1'b1;
      end else begin
        rsp_data_d = top_data;
        case (op_q)
          OP_POP:     sp_d   = sp_q - CNT_W'(1);
          OP_REPLACE: mem_we = 1'b1;
          OP_PEEK:    sp_d   = sp_q;
          default:    sp_d   = sp_q;
        endcase
      end
    end
  end

  // A set on the same edge as err_clr takes priority over the clear.
  always_comb begin
    ovf_d = ovf_set | (ovf_q & ~err_clr);
    udf_d = udf_set | (udf_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_PUSH;
      data_q     <= '0;
      sp_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      sp_q       <= sp_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // NOTE: storage is deliberately not reset; reads never reach entries at or above sp.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign count       = sp_q;
  assign empty       = is_empty;
  assign full        = is_full;
  assign almost_full = (sp_q >= CNT_W'(AFULL));
  assign ovf_sticky  = ovf_q;
  assign udf_sticky  = udf_q;

endmodule
